// File: rtl/sfp_norm.sv
// Purpose: sums |psum| over one row, swaps that sum with the peer core, then outputs floor(|x_i|*2^F/total) for each column.
// Latency: col + 1 + col*(bw_psum+F) edges from row capture to out_valid. Each cycle the peer is late in dual mode adds one edge.
// Backpressure: in_ready is high only in IDLE. A finished row is held on out until out_ready is seen.
module sfp_norm #(
    parameter int col     = 8,
    parameter int bw_psum = 20,
    parameter int F       = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mode,
    input  logic [bw_psum*col-1:0]   in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [bw_psum*col-1:0]   out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [bw_psum+3:0]       sum_out,
    output logic                     sum_valid,
    input  logic [bw_psum+3:0]       peer_sum,
    input  logic                     peer_valid
);

    localparam int DW = bw_psum + F;          // dividend width
    localparam int SW = bw_psum + 4;          // local sum width
    localparam int TW = bw_psum + 5;          // total width
    localparam int IW = (col > 1) ? $clog2(col) : 1;
    localparam int BW = $clog2(DW);
    localparam logic [BW-1:0] BMAX = BW'(DW - 1);
    localparam logic [IW-1:0] IMAX = IW'(col - 1);

    typedef enum logic [2:0] {IDLE, ACC, XCHG, DIV, DONE} state_t;

    state_t                   state_q, state_d;
    logic [bw_psum*col-1:0]   row_q;
    logic                     mode_q;
    logic [SW-1:0]            acc_q;
    logic [SW-1:0]            sum_q;
    logic [TW-1:0]            total_q;
    logic [IW-1:0]            idx_q;
    logic [BW-1:0]            bit_q;
    logic [TW-1:0]            rem_q;
    logic [bw_psum-1:0]       quo_q;
    logic [bw_psum*col-1:0]   out_q;

    logic [bw_psum-1:0]       cur_x;
    logic [bw_psum-1:0]       cur_abs;
    logic [DW-1:0]            dividend;
    logic                     dbit;
    logic [TW:0]              trial;
    logic                     qbit;
    logic [TW-1:0]            rem_nx;
    logic [bw_psum-1:0]       quo_nx;
    logic [SW-1:0]            acc_nx;
    logic                     idx_last;
    logic                     bit_last;

    // Column select, magnitude and one restoring-division step on the current column.
    always_comb begin
        cur_x    = row_q[int'(idx_q)*bw_psum +: bw_psum];
        // Unsigned result, so the most negative input maps to +2^(bw_psum-1).
        cur_abs  = cur_x[bw_psum-1] ? (~cur_x + 1'b1) : cur_x;
        dividend = {cur_abs, {F{1'b0}}};
        dbit     = dividend[BMAX - bit_q];
        trial    = {rem_q, dbit};
        // A zero total forces every quotient bit to 0. The step count stays the same, so latency is fixed.
        qbit     = (total_q != '0) && (trial >= {1'b0, total_q});
        rem_nx   = qbit ? TW'(trial - {1'b0, total_q}) : trial[TW-1:0];
        quo_nx   = bw_psum'({quo_q, qbit});
        acc_nx   = acc_q + SW'(cur_abs);
        idx_last = (idx_q == IMAX);
        bit_last = (bit_q == BMAX);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid)                  state_d = ACC;
            ACC:  if (idx_last)                  state_d = XCHG;
            XCHG: if (!mode_q || peer_valid)     state_d = DIV;
            DIV:  if (idx_last && bit_last)      state_d = DONE;
            DONE: if (out_ready)                 state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    // Datapath: capture the row, accumulate the sum, latch the total, then divide column by column.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q   <= '0;
            mode_q  <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            total_q <= '0;
            idx_q   <= '0;
            bit_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            out_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        row_q  <= in;
                        mode_q <= mode;
                        acc_q  <= '0;
                        idx_q  <= '0;
                    end
                end
                ACC: begin
                    acc_q <= acc_nx;
                    if (idx_last) begin
                        sum_q <= acc_nx;
                        idx_q <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                XCHG: begin
                    if (!mode_q)
                        total_q <= {1'b0, sum_q};
                    else if (peer_valid)
                        total_q <= {1'b0, sum_q} + {1'b0, peer_sum};
                    bit_q <= '0;
                    rem_q <= '0;
                    quo_q <= '0;
                end
                DIV: begin
                    if (bit_last) begin
                        out_q[int'(idx_q)*bw_psum +: bw_psum] <= quo_nx;
                        bit_q <= '0;
                        rem_q <= '0;
                        quo_q <= '0;
                        idx_q <= idx_last ? '0 : idx_q + 1'b1;
                    end else begin
                        bit_q <= bit_q + 1'b1;
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum_valid = (state_q == XCHG);
    assign out       = out_q;
    assign sum_out   = sum_q;

endmodule

// File: tb/tb_sfp_norm.sv
// Purpose: directed checks of sfp_norm: normalized values, sum exchange, latency, backpressure and reset.
// Latency: the bench measures edges from row capture to out_valid.
// Backpressure: holds out_ready low in DONE and checks that out stays put.
module tb_sfp_norm;
    localparam int COL = 8;
    localparam int BW  = 20;
    localparam int F   = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  mode;
    logic [BW*COL-1:0]     in;
    logic                  in_valid;
    logic                  in_ready;
    logic [BW*COL-1:0]     out;
    logic                  out_valid;
    logic                  out_ready;
    logic [BW+3:0]         sum_out;
    logic                  sum_valid;
    logic [BW+3:0]         peer_sum;
    logic                  peer_valid;

    always #5 clk = ~clk;

    sfp_norm #(.col(COL), .bw_psum(BW), .F(F)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .sum_valid (sum_valid),
        .peer_sum  (peer_sum),
        .peer_valid(peer_valid)
    );

    typedef struct {
        bit mode;
        int row[COL];
        bit peer_pre;
        int peer_s;
        int pdelay;
        int hold;
        int exp_sum;
        int exp_out[COL];
        int exp_lat;
        int exp_sv;
    } vec_t;

    vec_t vt[6];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [BW*COL-1:0] pack(input int r[COL]);
        logic [BW*COL-1:0] p;
        logic [31:0]       tmp;
        p = '0;
        for (int c = 0; c < COL; c++) begin
            tmp = r[c];
            p[c*BW +: BW] = tmp[BW-1:0];
        end
        return p;
    endfunction

    task automatic run_vec(input int v);
        vec_t          t;
        int            n;
        int            sv;
        int            first;
        bit            bad;
        bit            stable;
        logic [BW*COL-1:0] snap;
        t = vt[v];
        @(negedge clk);
        chk($sformatf("v%0d_idle_in_ready", v), in_ready, 1);
        in         = pack(t.row);
        mode       = t.mode;
        in_valid   = 1'b1;
        peer_sum   = (BW+4)'(t.peer_s);
        peer_valid = t.peer_pre;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0; sv = 0; first = -1; bad = 1'b0;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
            if (in_ready) bad = 1'b1;
            if (sum_valid) begin
                sv++;
                if (first < 0) first = n;
            end
            if (t.pdelay > 0 && first >= 0 && n - first == t.pdelay) peer_valid = 1'b1;
        end
        chk($sformatf("v%0d_latency", v), n, t.exp_lat);
        chk($sformatf("v%0d_sum_out", v), sum_out, t.exp_sum);
        chk($sformatf("v%0d_sum_valid_cycles", v), sv, t.exp_sv);
        chk($sformatf("v%0d_in_ready_while_busy", v), bad, 0);
        for (int c = 0; c < COL; c++)
            chk($sformatf("v%0d_out_col%0d", v, c), out[c*BW +: BW], t.exp_out[c]);
        snap   = out;
        stable = 1'b1;
        for (int h = 0; h < t.hold; h++) begin
            @(negedge clk);
            if (out !== snap || !out_valid || in_ready) stable = 1'b0;
        end
        if (t.hold > 0) chk($sformatf("v%0d_hold_stable", v), stable, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready  = 1'b0;
        peer_valid = 1'b0;
        chk($sformatf("v%0d_release_out_valid", v), out_valid, 0);
        chk($sformatf("v%0d_release_in_ready", v), in_ready, 1);
    endtask

    initial begin
        vt[0].mode = 0; vt[0].row = '{1, 2, 3, 4, -5, 6, 7, -8};
        vt[0].peer_pre = 0; vt[0].peer_s = 0; vt[0].pdelay = 0; vt[0].hold = 0;
        vt[0].exp_sum = 36; vt[0].exp_out = '{7, 14, 21, 28, 35, 42, 49, 56};
        vt[0].exp_lat = 233; vt[0].exp_sv = 1;

        vt[1].mode = 1; vt[1].row = '{1, 2, 3, 4, -5, 6, 7, -8};
        vt[1].peer_pre = 1; vt[1].peer_s = 36; vt[1].pdelay = 0; vt[1].hold = 0;
        vt[1].exp_sum = 36; vt[1].exp_out = '{3, 7, 10, 14, 17, 21, 24, 28};
        vt[1].exp_lat = 233; vt[1].exp_sv = 1;

        vt[2].mode = 1; vt[2].row = '{1, 2, 3, 4, -5, 6, 7, -8};
        vt[2].peer_pre = 0; vt[2].peer_s = 36; vt[2].pdelay = 20; vt[2].hold = 0;
        vt[2].exp_sum = 36; vt[2].exp_out = '{3, 7, 10, 14, 17, 21, 24, 28};
        vt[2].exp_lat = 253; vt[2].exp_sv = 21;

        vt[3].mode = 0; vt[3].row = '{100, 0, 0, 0, 0, 0, 0, 0};
        vt[3].peer_pre = 1; vt[3].peer_s = 999; vt[3].pdelay = 0; vt[3].hold = 0;
        vt[3].exp_sum = 100; vt[3].exp_out = '{256, 0, 0, 0, 0, 0, 0, 0};
        vt[3].exp_lat = 233; vt[3].exp_sv = 1;

        vt[4].mode = 0; vt[4].row = '{0, 0, 0, 0, 0, 0, 0, 0};
        vt[4].peer_pre = 0; vt[4].peer_s = 0; vt[4].pdelay = 0; vt[4].hold = 0;
        vt[4].exp_sum = 0; vt[4].exp_out = '{0, 0, 0, 0, 0, 0, 0, 0};
        vt[4].exp_lat = 233; vt[4].exp_sv = 1;

        vt[5].mode = 0; vt[5].row = '{0, 0, 0, -524288, 0, 0, 0, 0};
        vt[5].peer_pre = 0; vt[5].peer_s = 0; vt[5].pdelay = 0; vt[5].hold = 10;
        vt[5].exp_sum = 524288; vt[5].exp_out = '{0, 0, 0, 256, 0, 0, 0, 0};
        vt[5].exp_lat = 233; vt[5].exp_sv = 1;

        reset = 1'b0; mode = 1'b0; in = '0; in_valid = 1'b0;
        out_ready = 1'b0; peer_sum = '0; peer_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_sum_out", sum_out, 0);
        chk("rst_out_zero", (out == '0), 1);
        reset = 1'b1;

        for (int v = 0; v < 6; v++) run_vec(v);

        // Assert reset partway through DIV, then run a full row after release.
        @(negedge clk);
        in = pack(vt[0].row); mode = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (60) @(negedge clk);
        chk("middiv_busy", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("middiv_rst_out_valid", out_valid, 0);
        chk("middiv_rst_sum_valid", sum_valid, 0);
        chk("middiv_rst_in_ready", in_ready, 1);
        chk("middiv_rst_sum_out", sum_out, 0);
        chk("middiv_rst_out_zero", (out == '0), 1);
        @(negedge clk);
        reset = 1'b1;
        run_vec(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
